// File: rtl/fatorador_core_pkg.sv
// Shared definitions for the trial-division factorizer: widths, FSM states,
// initial divisor and the divisor step rule.
package fatorador_defs;

    localparam int NSLOT = 4;
    localparam int W     = 16;

    localparam logic [8:0] D_INIT = 9'd2;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_TEST = 3'd1,
        ST_DIV  = 3'd2,
        ST_UPD  = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    // Candidate divisors: 2, then odd numbers only (3, 5, 7, ...).
    function automatic logic [8:0] next_divisor(input logic [8:0] d);
        return (d == 9'd2) ? 9'd3 : d + 9'd2;
    endfunction

endpackage

// File: rtl/fatorador_core_divider.sv
// Restoring shift-subtract divider, one quotient bit per cycle.
// done pulses W+1 cycles after the start cycle; start is ignored while busy.
module seq_divider16
    import fatorador_defs::*;
(
    input  logic          CLOCK_50,
    input  logic          rst,
    input  logic          start,
    input  logic [W-1:0]  dividend,
    input  logic [W-1:0]  divisor,
    output logic          busy,
    output logic          done,
    output logic [W-1:0]  quot,
    output logic [W-1:0]  rem
);

    logic [W-1:0] r_quot;
    logic [W-1:0] r_rem;
    logic [W-1:0] r_div;
    logic [4:0]   r_cnt;
    logic         r_busy;
    logic         r_done;

    logic [W:0]   w_shift;
    logic [W-1:0] w_diff;

    // Partial remainder shifted left with the next dividend bit, and the trial difference.
    // When the subtraction succeeds the result is below the divisor, so 16 bits suffice.
    always_comb begin
        w_shift = {r_rem, r_quot[W-1]};
        w_diff  = w_shift[W-1:0] - r_div;
    end

    // Iteration register: load on start, then resolve one quotient bit per cycle.
    always_ff @(posedge CLOCK_50 or posedge rst) begin
        if (rst) begin
            r_quot <= '0;
            r_rem  <= '0;
            r_div  <= '0;
            r_cnt  <= '0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (start && !r_busy) begin
                r_quot <= dividend;
                r_rem  <= '0;
                r_div  <= divisor;
                r_cnt  <= '0;
                r_busy <= 1'b1;
            end else if (r_busy) begin
                if (w_shift >= {1'b0, r_div}) begin
                    r_rem  <= w_diff;
                    r_quot <= {r_quot[W-2:0], 1'b1};
                end else begin
                    r_rem  <= w_shift[W-1:0];
                    r_quot <= {r_quot[W-2:0], 1'b0};
                end
                r_cnt <= r_cnt + 5'd1;
                if (r_cnt == 5'(W - 1)) begin
                    r_busy <= 1'b0;
                    r_done <= 1'b1;
                end
            end
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign quot = r_quot;
    assign rem  = r_rem;

endmodule

// File: rtl/fatorador_core.sv
// Prime factorizer by sequential trial division. Up to four factors are
// reported in ascending order; ovf flags that more factors exist.
module fatorador_core
    import fatorador_defs::*;
(
    input  logic        CLOCK_50,
    input  logic        rst,
    input  logic        req,
    input  logic [15:0] n_in,
    output logic        ack,
    output logic [15:0] disp0,
    output logic [15:0] disp1,
    output logic [15:0] disp2,
    output logic [15:0] disp3,
    output logic [2:0]  nfact,
    output logic        ovf
);

    state_t       r_state;
    logic [W-1:0] r_n;
    logic [8:0]   r_d;
    logic [W-1:0] r_slot [NSLOT];
    logic [2:0]   r_nfact;
    logic         r_ovf;
    logic         r_ack;

    logic [16:0]  w_d17;
    logic [16:0]  w_sq;
    logic         w_n_small;
    logic         w_sq_gt;
    logic         w_start;
    logic         w_div_busy;
    logic         w_div_done;
    logic [W-1:0] w_quot;
    logic [W-1:0] w_rem;

    // Loop-exit tests; d stays <= 257 for 16-bit n, so d*d fits 17 bits.
    // Starting the divider straight from TEST saves one cycle per division.
    always_comb begin
        w_d17     = {8'd0, r_d};
        w_sq      = w_d17 * w_d17;
        w_n_small = (r_n < 16'd2);
        w_sq_gt   = (w_sq > {1'b0, r_n});
        w_start   = (r_state == ST_TEST) && !w_n_small && !w_sq_gt && !w_div_busy;
    end

    seq_divider16 u_div (
        .CLOCK_50 (CLOCK_50),
        .rst      (rst),
        .start    (w_start),
        .dividend (r_n),
        .divisor  ({7'd0, r_d}),
        .busy     (w_div_busy),
        .done     (w_div_done),
        .quot     (w_quot),
        .rem      (w_rem)
    );

    // Control FSM: accept request, test/divide loop, store factors, hold result.
    always_ff @(posedge CLOCK_50 or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_n     <= '0;
            r_d     <= D_INIT;
            r_nfact <= '0;
            r_ovf   <= 1'b0;
            r_ack   <= 1'b0;
            for (int i = 0; i < NSLOT; i++) r_slot[i] <= '0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (req) begin
                        r_n     <= n_in;
                        r_d     <= D_INIT;
                        r_nfact <= '0;
                        r_ovf   <= 1'b0;
                        r_ack   <= 1'b0;
                        for (int i = 0; i < NSLOT; i++) r_slot[i] <= '0;
                        r_state <= ST_TEST;
                    end
                end
                ST_TEST: begin
                    if (w_n_small) begin
                        r_ack   <= 1'b1;
                        r_state <= ST_DONE;
                    end else if (w_sq_gt) begin
                        // Remaining cofactor is prime.
                        if (r_nfact < 3'(NSLOT)) begin
                            r_slot[r_nfact[1:0]] <= r_n;
                            r_nfact              <= r_nfact + 3'd1;
                        end else begin
                            r_ovf <= 1'b1;
                        end
                        r_ack   <= 1'b1;
                        r_state <= ST_DONE;
                    end else begin
                        r_state <= ST_DIV;
                    end
                end
                ST_DIV: begin
                    if (w_div_done) r_state <= ST_UPD;
                end
                ST_UPD: begin
                    if (w_rem == '0) begin
                        if (r_nfact < 3'(NSLOT)) begin
                            r_slot[r_nfact[1:0]] <= {7'd0, r_d};
                            r_nfact              <= r_nfact + 3'd1;
                            r_n                  <= w_quot;
                            r_state              <= ST_TEST;
                        end else begin
                            r_ovf   <= 1'b1;
                            r_ack   <= 1'b1;
                            r_state <= ST_DONE;
                        end
                    end else begin
                        r_d     <= next_divisor(r_d);
                        r_state <= ST_TEST;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign ack   = r_ack;
    assign disp0 = r_slot[0];
    assign disp1 = r_slot[1];
    assign disp2 = r_slot[2];
    assign disp3 = r_slot[3];
    assign nfact = r_nfact;
    assign ovf   = r_ovf;

endmodule

// File: tb/tb_fatorador_core.sv
// Directed bench for fatorador_core: hand-computed factorizations, request
// handling while busy or done, and asynchronous reset during a division.
module tb_fatorador_core;

    logic        CLOCK_50 = 1'b0;
    logic        rst      = 1'b1;
    logic        req      = 1'b0;
    logic [15:0] n_in     = '0;
    logic        ack;
    logic [15:0] disp0, disp1, disp2, disp3;
    logic [2:0]  nfact;
    logic        ovf;

    int n_checks = 0;
    int n_pass   = 0;

    fatorador_core dut (
        .CLOCK_50 (CLOCK_50),
        .rst      (rst),
        .req      (req),
        .n_in     (n_in),
        .ack      (ack),
        .disp0    (disp0),
        .disp1    (disp1),
        .disp2    (disp2),
        .disp3    (disp3),
        .nfact    (nfact),
        .ovf      (ovf)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        assert (obs === exp_v) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    endtask

    // Issue a one-cycle request; inputs change 1 time unit after a rising edge.
    task automatic pulse_req(input logic [15:0] v);
        @(posedge CLOCK_50); #1;
        req  = 1'b1;
        n_in = v;
        @(posedge CLOCK_50); #1;
        req  = 1'b0;
    endtask

    // Wait for ack with a cycle budget; returns the cycles waited after the req edge.
    task automatic wait_ack(input string tag, input int max_cyc, output int waited);
        waited = 0;
        while (ack !== 1'b1 && waited < max_cyc) begin
            @(posedge CLOCK_50); #1;
            waited++;
        end
        chk({tag, "_ack"}, {31'd0, ack}, 32'd1);
    endtask

    task automatic chk_result(input string tag,
                              input logic [15:0] e0, input logic [15:0] e1,
                              input logic [15:0] e2, input logic [15:0] e3,
                              input logic [2:0] enf, input logic eovf);
        chk({tag, "_d0"},   {16'd0, disp0}, {16'd0, e0});
        chk({tag, "_d1"},   {16'd0, disp1}, {16'd0, e1});
        chk({tag, "_d2"},   {16'd0, disp2}, {16'd0, e2});
        chk({tag, "_d3"},   {16'd0, disp3}, {16'd0, e3});
        chk({tag, "_nf"},   {29'd0, nfact}, {29'd0, enf});
        chk({tag, "_ovf"},  {31'd0, ovf},   {31'd0, eovf});
    endtask

    initial begin
        int w;

        // Reset state
        repeat (3) @(posedge CLOCK_50);
        #1;
        chk_result("rst", 16'd0, 16'd0, 16'd0, 16'd0, 3'd0, 1'b0);
        chk("rst_ack", {31'd0, ack}, 32'd0);
        rst = 1'b0;

        // 12 = 2*2*3
        pulse_req(16'd12);
        chk("n12_busy_ack", {31'd0, ack}, 32'd0);
        wait_ack("n12", 400, w);
        chk_result("n12", 16'd2, 16'd2, 16'd3, 16'd0, 3'd3, 1'b0);

        // 60 = 2*2*3*5, exactly four slots, no overflow
        pulse_req(16'd60);
        chk("n60_ack_drop", {31'd0, ack}, 32'd0);
        wait_ack("n60", 400, w);
        chk_result("n60", 16'd2, 16'd2, 16'd3, 16'd5, 3'd4, 1'b0);

        // 1024 = 2^10, overflow after four slots
        pulse_req(16'd1024);
        wait_ack("n1024", 400, w);
        chk_result("n1024", 16'd2, 16'd2, 16'd2, 16'd2, 3'd4, 1'b1);

        // 65521 is prime: worst-case run
        pulse_req(16'd65521);
        wait_ack("n65521", 2600, w);
        chk_result("n65521", 16'd65521, 16'd0, 16'd0, 16'd0, 3'd1, 1'b0);

        // 65535 = 3*5*17*257
        pulse_req(16'd65535);
        wait_ack("n65535", 2600, w);
        chk_result("n65535", 16'd3, 16'd5, 16'd17, 16'd257, 3'd4, 1'b0);

        // 0 and 1: immediate completion, empty result
        pulse_req(16'd0);
        wait_ack("n0", 3, w);
        chk("n0_lat", {31'd0, (w <= 2)}, 32'd1);
        chk_result("n0", 16'd0, 16'd0, 16'd0, 16'd0, 3'd0, 1'b0);
        pulse_req(16'd1);
        wait_ack("n1", 3, w);
        chk("n1_lat", {31'd0, (w <= 2)}, 32'd1);
        chk_result("n1", 16'd0, 16'd0, 16'd0, 16'd0, 3'd0, 1'b0);

        // 9991 = 97*103; a second request while busy is ignored
        pulse_req(16'd9991);
        repeat (40) @(posedge CLOCK_50);
        #1;
        pulse_req(16'd500);
        chk("n9991_busy_ack", {31'd0, ack}, 32'd0);
        wait_ack("n9991", 2600, w);
        chk_result("n9991", 16'd97, 16'd103, 16'd0, 16'd0, 3'd2, 1'b0);

        // Request in DONE: ack drops on the accepting edge; 49 = 7*7
        pulse_req(16'd49);
        chk("n49_ack_drop", {31'd0, ack}, 32'd0);
        wait_ack("n49", 600, w);
        chk_result("n49", 16'd7, 16'd7, 16'd0, 16'd0, 3'd2, 1'b0);

        // Asynchronous reset in the middle of a division
        pulse_req(16'd65521);
        repeat (100) @(posedge CLOCK_50);
        #3;
        rst = 1'b1;
        #1;
        chk_result("midrst", 16'd0, 16'd0, 16'd0, 16'd0, 3'd0, 1'b0);
        chk("midrst_ack", {31'd0, ack}, 32'd0);
        repeat (2) @(posedge CLOCK_50);
        #1;
        rst = 1'b0;
        chk("post_rst_ack", {31'd0, ack}, 32'd0);

        // 6 = 2*3 after reset release
        pulse_req(16'd6);
        wait_ack("n6", 400, w);
        chk_result("n6", 16'd2, 16'd3, 16'd0, 16'd0, 3'd2, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
